// File: rtl/code_entry_fsm_if.sv
// Key-pulse inputs and display/status outputs of the code entry controller.
interface code_entry_fsm_if;
  logic [9:0]  key_num;
  logic        key_enter;
  logic        key_clear;
  logic [15:0] code_disp;
  logic [2:0]  digit_cnt;
  logic        fire;
  logic        err_pulse;
  logic [1:0]  fail_cnt;
  logic        locked;

  modport master (
    output key_num, key_enter, key_clear,
    input  code_disp, digit_cnt, fire, err_pulse, fail_cnt, locked
  );

  modport slave (
    input  key_num, key_enter, key_clear,
    output code_disp, digit_cnt, fire, err_pulse, fail_cnt, locked
  );
endinterface

// File: rtl/code_entry_fsm.sv
// Password entry controller: collects a 4-digit BCD code, fires on a match, locks out after repeated failures.
// Optional macro ENTRY_TIMEOUT_EN adds an inactivity timeout that discards a partial entry.
//
// state    | meaning
// ST_ENTRY | collecting digits, waiting for ENTER/CLEAR
// ST_CHECK | one-cycle compare against PASSWORD
// ST_FIRE  | code matched, fire held until CLEAR
// ST_LOCK  | too many failures, all keys ignored until the lock timer expires
module code_entry_fsm #(
  parameter logic [15:0] PASSWORD       = 16'h1234,
  parameter int          MAX_FAIL       = 3,
  parameter int          LOCK_CYCLES    = 500_000_000,
  parameter int          TIMEOUT_CYCLES = 1_000_000_000
) (
  input logic             clk,
  input logic             rst,
  code_entry_fsm_if.slave bus
);

  typedef enum logic [1:0] {ST_ENTRY, ST_CHECK, ST_FIRE, ST_LOCK} state_t;

  localparam int          TW       = $clog2(LOCK_CYCLES) + 1;
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  localparam logic [1:0]  MAX_FAIL_V = 2'(MAX_FAIL);

  state_t        state, state_nxt;
  logic [15:0]   code_q, code_nxt;
  logic [2:0]    cnt_q, cnt_nxt;
  logic [1:0]    fail_q, fail_nxt, fail_inc;
  logic          fire_q, fire_nxt;
  logic          err_q, err_nxt;
  logic          locked_q, locked_nxt;
  logic [TW-1:0] timer_q, timer_nxt;
  logic          digit_ok;
  logic [3:0]    digit_val;

  function automatic logic [3:0] encode_digit(input logic [9:0] k);
    logic [3:0] d;
    d = '0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) d = 4'(i);
    end
    return d;
  endfunction

  assign digit_ok  = $onehot(bus.key_num);
  assign digit_val = encode_digit(bus.key_num);
  assign fail_inc  = (fail_q >= MAX_FAIL_V) ? MAX_FAIL_V : fail_q + 2'd1;

`ifdef ENTRY_TIMEOUT_EN
  localparam int          IW      = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
  logic [IW-1:0] idle_q, idle_nxt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_nxt  = state;
    code_nxt   = code_q;
    cnt_nxt    = cnt_q;
    fail_nxt   = fail_q;
    fire_nxt   = fire_q;
    err_nxt    = 1'b0;
    locked_nxt = locked_q;
    timer_nxt  = timer_q;
`ifdef ENTRY_TIMEOUT_EN
    idle_nxt   = '0;
`endif
    case (state)
      ST_ENTRY: begin
        if (bus.key_clear) begin
          code_nxt = '0;
          cnt_nxt  = '0;
        end else if (bus.key_enter) begin
          if (cnt_q == 3'd4) begin
            state_nxt = ST_CHECK;
          end else begin
            err_nxt  = 1'b1;
            code_nxt = '0;
            cnt_nxt  = '0;
          end
        end else if (digit_ok && cnt_q < 3'd4) begin
          code_nxt = {code_q[11:0], digit_val};
          cnt_nxt  = cnt_q + 3'd1;
        end
`ifdef ENTRY_TIMEOUT_EN
        // Keys take priority; the timeout fires only on a quiet cycle.
        if (cnt_q != 3'd0 && !(bus.key_clear || bus.key_enter || digit_ok)) begin
          if (idle_q == IDLE_LAST) begin
            code_nxt = '0;
            cnt_nxt  = '0;
            err_nxt  = 1'b1;
          end else begin
            idle_nxt = idle_q + 1'b1;
          end
        end
`endif
      end
      ST_CHECK: begin
        if (code_q == PASSWORD) begin
          state_nxt = ST_FIRE;
          fail_nxt  = '0;
          fire_nxt  = 1'b1;
        end else begin
          err_nxt  = 1'b1;
          code_nxt = '0;
          cnt_nxt  = '0;
          fail_nxt = fail_inc;
          if (fail_inc == MAX_FAIL_V) begin
            state_nxt  = ST_LOCK;
            timer_nxt  = LOCK_LOAD;
            locked_nxt = 1'b1;
          end else begin
            state_nxt = ST_ENTRY;
          end
        end
      end
      ST_FIRE: begin
        if (bus.key_clear) begin
          fire_nxt  = 1'b0;
          code_nxt  = '0;
          cnt_nxt   = '0;
          state_nxt = ST_ENTRY;
        end
      end
      ST_LOCK: begin
        if (timer_q == '0) begin
          locked_nxt = 1'b0;
          fail_nxt   = '0;
          state_nxt  = ST_ENTRY;
        end else begin
          timer_nxt = timer_q - 1'b1;
        end
      end
      default: state_nxt = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_ENTRY;
      code_q   <= '0;
      cnt_q    <= '0;
      fail_q   <= '0;
      fire_q   <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      timer_q  <= '0;
    end else begin
      state    <= state_nxt;
      code_q   <= code_nxt;
      cnt_q    <= cnt_nxt;
      fail_q   <= fail_nxt;
      fire_q   <= fire_nxt;
      err_q    <= err_nxt;
      locked_q <= locked_nxt;
      timer_q  <= timer_nxt;
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_nxt;
  end
`endif

  assign bus.code_disp = code_q;
  assign bus.digit_cnt = cnt_q;
  assign bus.fail_cnt  = fail_q;
  assign bus.fire      = fire_q;
  assign bus.err_pulse = err_q;
  assign bus.locked    = locked_q;

endmodule
